csa_accum_pipe: RTL and testbench

- Multi-beat carry-save accumulator built around a 5:2 compressor.
- Each accepted beat adds NUM_OPS new operands to a redundant (sum, carry) accumulator held in registers.
- The packet result is presented in redundant form with a valid/ready handshake, together with a beat count.
- Sits between operand generators and a final resolver or online digit-selection stage; there is no carry-propagate adder inside.

---
 rtl/csa_pkg.sv | 27 ++
 rtl/csa_accum_pipe_if.sv | 31 +++
 rtl/csa_5_2.sv | 38 +++
 rtl/csa_accum_pipe.sv | 134 +++++++++++++
 tb/tb_csa_accum_pipe.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator.
//   acc_state_e : accumulator control states
//   ext_op()    : sign- or zero-extends an operand of `width` bits to
//                 EXT_MAX_W bits; callers keep the low ACC_W bits.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  localparam int EXT_MAX_W = 64;

  function automatic logic [EXT_MAX_W-1:0] ext_op(input logic [EXT_MAX_W-1:0] value,
                                                  input int width,
                                                  input bit is_signed);
    logic [EXT_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i < width) r[i] = value[i];
      else           r[i] = is_signed ? value[width-1] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_accum_pipe_if.sv
// Beat input / redundant result output bundle of csa_accum_pipe.
//   in_valid/in_ready/in_first/in_last/in_ops : operand beat stream
//   out_valid/out_ready/out_sum/out_carry/out_count : packet result
// master = producer/consumer side, slave = accumulator side.
interface csa_accum_pipe_if #(
  parameter int WIDTH   = 11,
  parameter int NUM_OPS = 3,
  parameter int ACC_W   = 15,
  parameter int CNT_W   = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_first;
  logic                     in_last;
  logic [NUM_OPS*WIDTH-1:0] in_ops;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_sum;
  logic [ACC_W-1:0]         out_carry;
  logic [CNT_W-1:0]         out_count;

  modport master (
    output in_valid, in_first, in_last, in_ops, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

  modport slave (
    input  in_valid, in_first, in_last, in_ops, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );
endinterface

// File: rtl/csa_5_2.sv
// 5:2 carry-save compressor built from three full-adder rows.
//   a..e        : five WIDTH-bit addends
//   cin1, cin2  : carries into bit 0
//   sum, carry  : redundant result; carry bit i has weight 2^(i+1)
//   cout1/cout2 : carries out of the top bit
// Row 1 and row 2 couts travel one bit left as that bit's cin1/cin2, so no
// carry ever ripples more than one position.
module csa_5_2 #(
  parameter int WIDTH = 15
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic             cin1,
  input  logic             cin2,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout1,
  output logic             cout2
);
  logic [WIDTH-1:0] s1, c1, s2, c2;
  logic [WIDTH:0]   ci1, ci2;

  assign s1  = a ^ b ^ c;
  assign c1  = (a & b) | (a & c) | (b & c);
  assign s2  = s1 ^ d ^ e;
  assign c2  = (s1 & d) | (s1 & e) | (d & e);
  assign ci1 = {c1, cin1};
  assign ci2 = {c2, cin2};

  assign sum   = s2 ^ ci1[WIDTH-1:0] ^ ci2[WIDTH-1:0];
  assign carry = (s2 & ci1[WIDTH-1:0]) | (s2 & ci2[WIDTH-1:0]) |
                 (ci1[WIDTH-1:0] & ci2[WIDTH-1:0]);
  assign cout1 = ci1[WIDTH];
  assign cout2 = ci2[WIDTH];
endmodule

// File: rtl/csa_accum_pipe.sv
// Multi-beat carry-save accumulator. Each accepted beat folds NUM_OPS
// operands into a redundant (sum, carry) accumulator through one 5:2
// compressor; the last beat of a packet registers the redundant result and
// the saturating beat count, presented with a valid/ready handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : csa_accum_pipe_if slave (beat stream in, result out)
module csa_accum_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int NUM_OPS = 3,
  parameter int GUARD   = 4,
  parameter int SIGNED  = 1,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  csa_accum_pipe_if.slave bus
);
  localparam int ACC_W = WIDTH + GUARD;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
  logic [ACC_W-1:0] acc_carry_q, acc_carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [ACC_W-1:0] out_carry_q, out_carry_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic signed [ACC_W-1:0] op_ext [3];
  logic [ACC_W-1:0]        d_in, e_in, csa_sum, csa_carry;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    in_ready, accept, first_beat;
  logic                    csa_cout1_unused, csa_cout2_unused;
  logic                    acc_carry_msb_unused;

  // Operand extension; unused compressor slots are tied to zero.
  for (genvar k = 0; k < 3; k++) begin : g_op
    if (k < NUM_OPS) begin : g_used
      logic [EXT_MAX_W-ACC_W-1:0] ext_hi_unused;
      assign {ext_hi_unused, op_ext[k]} =
        ext_op(EXT_MAX_W'(bus.in_ops[k*WIDTH +: WIDTH]), WIDTH, SIGNED != 0);
    end else begin : g_tied
      assign op_ext[k] = '0;
    end
  end

  assign in_ready   = (state_q != HOLD) | bus.out_ready;
  assign accept     = bus.in_valid & in_ready;
  // Only a beat landing in ACCUM without in_first continues a packet.
  assign first_beat = bus.in_first | (state_q != ACCUM);

  assign d_in    = first_beat ? '0 : acc_sum_q;
  // Carry bits weigh 2^(i+1); the top carry bit falls outside ACC_W.
  assign e_in    = first_beat ? '0 : {acc_carry_q[ACC_W-2:0], 1'b0};
  assign cnt_inc = first_beat ? CNT_W'(1) : sat_inc(cnt_q);
  assign acc_carry_msb_unused = acc_carry_q[ACC_W-1];

  csa_5_2 #(.WIDTH(ACC_W)) u_csa (
    .a     (op_ext[0]),
    .b     (op_ext[1]),
    .c     (op_ext[2]),
    .d     (d_in),
    .e     (e_in),
    .cin1  (1'b0),
    .cin2  (1'b0),
    .sum   (csa_sum),
    .carry (csa_carry),
    .cout1 (csa_cout1_unused),
    .cout2 (csa_cout2_unused)
  );

  always_comb begin
    state_d     = state_q;
    acc_sum_d   = acc_sum_q;
    acc_carry_d = acc_carry_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_count_d = out_count_q;

    case (state_q)
      IDLE, ACCUM, HOLD: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (bus.in_last) begin
            out_sum_d   = csa_sum;
            out_carry_d = csa_carry;
            out_count_d = cnt_inc;
            state_d     = HOLD;
          end else begin
            acc_sum_d   = csa_sum;
            acc_carry_d = csa_carry;
            state_d     = ACCUM;
          end
        end else if (state_q == HOLD && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: control, accumulator and result all clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_sum_q   <= '0;
      acc_carry_q <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_carry_q <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_sum_q   <= acc_sum_d;
      acc_carry_q <= acc_carry_d;
      cnt_q       <= cnt_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_carry = out_carry_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_csa_accum_pipe.sv
module tb_csa_accum_pipe;
  localparam int WIDTH   = 11;
  localparam int NUM_OPS = 3;
  localparam int GUARD   = 4;
  localparam int ACC_W   = WIDTH + GUARD;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csa_accum_pipe_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  csa_accum_pipe #(
    .WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .GUARD(GUARD), .SIGNED(1), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Value represented by the redundant output pair, modulo 2^ACC_W.
  function automatic int resolved();
    logic [ACC_W-1:0] r;
    r = bus.out_sum + (bus.out_carry << 1);
    return int'(r);
  endfunction

  function automatic int sx(input int v);
    logic [WIDTH-1:0] t;
    t = v[WIDTH-1:0];
    return int'($signed(t));
  endfunction

  task automatic drive(input bit v, input bit f, input bit l,
                       input int o0, input int o1, input int o2, input bit ordy);
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.in_last   = l;
    bus.in_ops    = {o2[WIDTH-1:0], o1[WIDTH-1:0], o0[WIDTH-1:0]};
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, int'($urandom), int'($urandom), int'($urandom), 0);
    tick();
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    tests_run++;
    if (bus.out_sum !== '0) begin tests_failed++; $display("FAIL reset_sum got %0h want 0", bus.out_sum); end
    tests_run++;
    if (bus.out_carry !== '0) begin tests_failed++; $display("FAIL reset_carry got %0h want 0", bus.out_carry); end
    tests_run++;
    if (bus.out_count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", bus.out_count); end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %0b want 1", bus.in_ready); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_no_accept got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_single();
    drive(1, 1, 1, 5, 7, -3, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %0b want 1", bus.out_valid); end
    tests_run++;
    if (resolved() != 9) begin tests_failed++; $display("FAIL single_value got %0d want 9", resolved()); end
    tests_run++;
    if (bus.out_count !== 8'd1) begin tests_failed++; $display("FAIL single_count got %0d want 1", bus.out_count); end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_consume got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    drive(1, 1, 0, 1023, 1023, 1023, 0); tick();
    drive(1, 0, 0, 1023, 1023, 1023, 0); tick();
    drive(1, 0, 1, 1023, 1023, 1023, 0); tick();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid got %0b want 1", bus.out_valid); end
    drive(1, 1, 1, int'($urandom), int'($urandom), int'($urandom), 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready cyc %0d got %0b want 0", i, bus.in_ready); end
      tests_run++;
      if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold_valid cyc %0d got %0b want 1", i, bus.out_valid); end
      tests_run++;
      if (resolved() != 9207) begin tests_failed++; $display("FAIL stall_value cyc %0d got %0d want 9207", i, resolved()); end
      tests_run++;
      if (bus.out_count !== 8'd3) begin tests_failed++; $display("FAIL stall_count cyc %0d got %0d want 3", i, bus.out_count); end
      tick();
    end
  endtask

  // Entered with the stalled 9207 result still held.
  task automatic test_back_to_back();
    drive(1, 1, 1, 1, 2, 3, 1);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready got %0b want 1", bus.in_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid got %0b want 1", bus.out_valid); end
    tests_run++;
    if (resolved() != 6) begin tests_failed++; $display("FAIL b2b_value got %0d want 6", resolved()); end
    tests_run++;
    if (bus.out_count !== 8'd1) begin tests_failed++; $display("FAIL b2b_count got %0d want 1", bus.out_count); end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_consume got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_negative();
    for (int i = 0; i < 8; i++) begin
      drive(1, i == 0, i == 7, -1024, -1024, -1024, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (resolved() != 8192) begin tests_failed++; $display("FAIL neg_value got %0d want 8192", resolved()); end
    tests_run++;
    if (bus.out_count !== 8'd8) begin tests_failed++; $display("FAIL neg_count got %0d want 8", bus.out_count); end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_restart();
    drive(1, 1, 0, 10, 0, 0, 0); tick();
    drive(1, 1, 1, 4, 0, 0, 0);  tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (resolved() != 4) begin tests_failed++; $display("FAIL restart_value got %0d want 4", resolved()); end
    tests_run++;
    if (bus.out_count !== 8'd1) begin tests_failed++; $display("FAIL restart_count got %0d want 1", bus.out_count); end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1, i == 0, i == 299, 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tests_run++;
    if (resolved() != 300) begin tests_failed++; $display("FAIL sat_value got %0d want 300", resolved()); end
    tests_run++;
    if (bus.out_count !== 8'd255) begin tests_failed++; $display("FAIL sat_count got %0d want 255", bus.out_count); end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  // Packet-level model: running integer sum and beat count per packet,
  // plus whether a result is waiting to be taken.
  task automatic test_random();
    bit hold = 0, open = 0, v, f, l, ordy, exp_rdy;
    int exp_res = 0, exp_cnt = 0, run = 0, cnt = 0;
    int pkts = 0, beat = 0, len, o0, o1, o2;
    len = int'($urandom_range(1, 6));
    for (int cyc = 0; cyc < 3000 && pkts < 40; cyc++) begin
      tests_run++;
      if (bus.out_valid !== hold) begin tests_failed++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, bus.out_valid, hold); end
      if (hold) begin
        tests_run++;
        if (resolved() != exp_res) begin tests_failed++; $display("FAIL rnd_value cyc %0d got %0d want %0d", cyc, resolved(), exp_res); end
        tests_run++;
        if (int'(bus.out_count) != exp_cnt) begin tests_failed++; $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, bus.out_count, exp_cnt); end
      end
      v    = ($urandom % 4) != 0;
      ordy = $urandom % 2;
      f    = (beat == 0) || (($urandom % 8) == 0);
      l    = (beat == len - 1);
      o0   = int'($urandom_range(0, 2047));
      o1   = int'($urandom_range(0, 2047));
      o2   = int'($urandom_range(0, 2047));
      drive(v, f, l, o0, o1, o2, ordy);
      #1;
      exp_rdy = !hold || ordy;
      tests_run++;
      if (bus.in_ready !== exp_rdy) begin tests_failed++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", cyc, bus.in_ready, exp_rdy); end
      if (v && exp_rdy) begin
        if (f || !open) begin
          run = sx(o0) + sx(o1) + sx(o2);
          cnt = 1;
        end else begin
          run = run + sx(o0) + sx(o1) + sx(o2);
          cnt = (cnt < 255) ? cnt + 1 : 255;
        end
        if (l) begin
          hold    = 1;
          open    = 0;
          exp_res = run & 32'h7fff;
          exp_cnt = cnt;
          pkts++;
          beat    = 0;
          len     = int'($urandom_range(1, 6));
        end else begin
          hold = 0;
          open = 1;
          beat++;
        end
      end else if (hold && ordy) begin
        hold = 0;
      end
      tick();
    end
    tests_run++;
    if (pkts != 40) begin tests_failed++; $display("FAIL rnd_packets got %0d want 40", pkts); end
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_negative();
    test_restart();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end
endmodule
